// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: PC source selection, imem request/ack handshake,
// redirect arbitration (exception > branch > timeout) and IF/ID strobes.
module fetch_ctrl #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_in,
  input  logic            branch_taken_in,
  input  logic [XLEN-1:0] branch_offset_in,
  input  logic            exception_in,
  input  logic            imem_ack_in,
  output logic [1:0]      pc_src_out,
  output logic [XLEN-1:0] alt_pc_out,
  output logic            imem_req_out,
  output logic            if_capture_out,
  output logic            if_valid_out,
  output logic            flush_out,
  output logic            fetch_fault_out
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] SRC_ALT  = 2'd0;
  localparam logic [1:0] SRC_SEQ  = 2'd1;
  localparam logic [1:0] SRC_EXC  = 2'd2;
  localparam logic [1:0] SRC_ZERO = 2'd3;

  typedef enum logic [1:0] {BOOT, REQ, HELD, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             req_active;
  logic             ack;
  logic             timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    pc_src_out      = SRC_ALT;
    alt_pc_out      = '0;
    imem_req_out    = 1'b0;
    if_capture_out  = 1'b0;
    if_valid_out    = 1'b0;
    flush_out       = 1'b0;
    fetch_fault_out = 1'b0;
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;

    // Request is held high through stalls until acked, so it depends on state only.
    req_active   = (state == REQ) || (state == DRAIN);
    imem_req_out = req_active;
    ack          = req_active && imem_ack_in;
    timeout      = req_active && !imem_ack_in && (wait_cnt == CNT_LAST);

    case (state)
      BOOT: begin
        pc_src_out   = SRC_ZERO;
        state_nxt    = REQ;
        wait_cnt_nxt = '0;
      end
      default: begin
        if_capture_out = ack;
        if (exception_in || branch_taken_in || timeout) begin
          flush_out    = 1'b1;
          wait_cnt_nxt = '0;
          // An unacked request must still be completed before fetching anew.
          state_nxt    = (req_active && !imem_ack_in) ? DRAIN : REQ;
          if (exception_in) begin
            pc_src_out = SRC_EXC;
          end else if (branch_taken_in) begin
            pc_src_out = SRC_ALT;
            alt_pc_out = branch_offset_in;
          end else begin
            pc_src_out      = SRC_EXC;
            fetch_fault_out = 1'b1;
          end
        end else begin
          case (state)
            REQ: begin
              if (ack) begin
                wait_cnt_nxt = '0;
                if (!stall_in) begin
                  pc_src_out   = SRC_SEQ;
                  if_valid_out = 1'b1;
                end else begin
                  state_nxt = HELD;
                end
              end else begin
                wait_cnt_nxt = sat_inc(wait_cnt);
              end
            end
            HELD: begin
              wait_cnt_nxt = '0;
              if (!stall_in) begin
                pc_src_out   = SRC_SEQ;
                if_valid_out = 1'b1;
                state_nxt    = REQ;
              end
            end
            DRAIN: begin
              if (ack) begin
                wait_cnt_nxt = '0;
                state_nxt    = REQ;
              end else begin
                wait_cnt_nxt = sat_inc(wait_cnt);
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl with a small PC register model.
module tb_fetch_ctrl;

  localparam int          XLEN     = 32;
  localparam int          TO       = 4;
  localparam logic [31:0] EXC_ADDR = 32'h100;
  localparam int          NV       = 27;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            stall_in = 1'b0;
  logic            branch_taken_in = 1'b0;
  logic [XLEN-1:0] branch_offset_in = '0;
  logic            exception_in = 1'b0;
  logic            imem_ack_in = 1'b0;
  logic [1:0]      pc_src_out;
  logic [XLEN-1:0] alt_pc_out;
  logic            imem_req_out;
  logic            if_capture_out;
  logic            if_valid_out;
  logic            flush_out;
  logic            fetch_fault_out;
  logic [31:0]     pc;

  always #5 clk = ~clk;

  fetch_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_in         (stall_in),
    .branch_taken_in  (branch_taken_in),
    .branch_offset_in (branch_offset_in),
    .exception_in     (exception_in),
    .imem_ack_in      (imem_ack_in),
    .pc_src_out       (pc_src_out),
    .alt_pc_out       (alt_pc_out),
    .imem_req_out     (imem_req_out),
    .if_capture_out   (if_capture_out),
    .if_valid_out     (if_valid_out),
    .flush_out        (flush_out),
    .fetch_fault_out  (fetch_fault_out)
  );

  // PC register of the surrounding datapath, driven by the controller's select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= '0;
    else begin
      case (pc_src_out)
        2'd0:    pc <= pc + alt_pc_out;
        2'd1:    pc <= pc + 32'd4;
        2'd2:    pc <= EXC_ADDR;
        default: pc <= '0;
      endcase
    end
  end

  typedef struct {
    int rst, stall, br, off, exc, ack;
    int src, alt, req, cap, vld, fl, flt, pc;
  } vec_t;

  vec_t tbl [NV];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row %0d %s: got 0x%0h expected 0x%0h", row, name, act, exp);
    end
  endtask

  task automatic check_outs(input int row, input vec_t v);
    chk("pc_src",  row, 32'(pc_src_out),      32'(v.src));
    chk("alt_pc",  row, alt_pc_out,           32'(v.alt));
    chk("req",     row, 32'(imem_req_out),    32'(v.req));
    chk("capture", row, 32'(if_capture_out),  32'(v.cap));
    chk("valid",   row, 32'(if_valid_out),    32'(v.vld));
    chk("flush",   row, 32'(flush_out),       32'(v.fl));
    chk("fault",   row, 32'(fetch_fault_out), 32'(v.flt));
    chk("pc",      row, pc,                   32'(v.pc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   nreq;
    logic seen;
    vec_t rv;
    //          rst st br off    exc ack  src alt    req cap vld fl flt pc
    tbl[0]  = '{1, 0, 0, 0,     0,  1,   3,  0,     0,  0,  0,  0, 0,  0};
    tbl[1]  = '{1, 0, 0, 0,     0,  1,   1,  0,     1,  1,  1,  0, 0,  0};
    tbl[2]  = '{1, 0, 0, 0,     0,  1,   1,  0,     1,  1,  1,  0, 0,  4};
    tbl[3]  = '{1, 0, 0, 0,     0,  1,   1,  0,     1,  1,  1,  0, 0,  8};
    tbl[4]  = '{1, 1, 0, 0,     0,  0,   0,  0,     1,  0,  0,  0, 0,  12};
    tbl[5]  = '{1, 1, 0, 0,     0,  0,   0,  0,     1,  0,  0,  0, 0,  12};
    tbl[6]  = '{1, 1, 0, 0,     0,  1,   0,  0,     1,  1,  0,  0, 0,  12};
    tbl[7]  = '{1, 1, 0, 0,     0,  0,   0,  0,     0,  0,  0,  0, 0,  12};
    tbl[8]  = '{1, 1, 0, 0,     0,  0,   0,  0,     0,  0,  0,  0, 0,  12};
    tbl[9]  = '{1, 0, 0, 0,     0,  0,   1,  0,     0,  0,  1,  0, 0,  12};
    tbl[10] = '{1, 0, 0, 0,     0,  0,   0,  0,     1,  0,  0,  0, 0,  16};
    tbl[11] = '{1, 0, 1, 'h20,  0,  0,   0,  'h20,  1,  0,  0,  1, 0,  16};
    tbl[12] = '{1, 0, 0, 0,     0,  0,   0,  0,     1,  0,  0,  0, 0,  'h30};
    tbl[13] = '{1, 0, 0, 0,     0,  1,   0,  0,     1,  1,  0,  0, 0,  'h30};
    tbl[14] = '{1, 0, 0, 0,     0,  0,   0,  0,     1,  0,  0,  0, 0,  'h30};
    tbl[15] = '{1, 0, 0, 0,     0,  0,   0,  0,     1,  0,  0,  0, 0,  'h30};
    tbl[16] = '{1, 0, 0, 0,     0,  0,   0,  0,     1,  0,  0,  0, 0,  'h30};
    tbl[17] = '{1, 0, 0, 0,     0,  0,   2,  0,     1,  0,  0,  1, 1,  'h30};
    tbl[18] = '{1, 0, 0, 0,     0,  1,   0,  0,     1,  1,  0,  0, 0,  'h100};
    tbl[19] = '{1, 0, 0, 0,     0,  1,   1,  0,     1,  1,  1,  0, 0,  'h100};
    tbl[20] = '{1, 0, 1, 'h40,  1,  0,   2,  0,     1,  0,  0,  1, 0,  'h104};
    tbl[21] = '{1, 0, 0, 0,     0,  0,   0,  0,     1,  0,  0,  0, 0,  'h100};
    tbl[22] = '{0, 0, 0, 0,     0,  0,   3,  0,     0,  0,  0,  0, 0,  0};
    tbl[23] = '{1, 0, 0, 0,     0,  0,   3,  0,     0,  0,  0,  0, 0,  0};
    tbl[24] = '{1, 1, 1, 8,     0,  1,   0,  8,     1,  1,  0,  1, 0,  0};
    tbl[25] = '{1, 0, 0, 0,     0,  1,   1,  0,     1,  1,  1,  0, 0,  8};
    tbl[26] = '{1, 0, 0, 0,     0,  0,   0,  0,     1,  0,  0,  0, 0,  12};

    // Reset state while rst_n is held low
    repeat (2) @(negedge clk);
    #1;
    rv = '{0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0};
    check_outs(-1, rv);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst_n            = 1'(tbl[i].rst);
      stall_in         = 1'(tbl[i].stall);
      branch_taken_in  = 1'(tbl[i].br);
      branch_offset_in = 32'(tbl[i].off);
      exception_in     = 1'(tbl[i].exc);
      imem_ack_in      = 1'(tbl[i].ack);
      #1;
      check_outs(i, tbl[i]);
    end

    // Fault must land on exactly the TO-th request cycle, as a single-cycle pulse.
    @(negedge clk);
    rst_n = 1'b0; stall_in = 1'b0; branch_taken_in = 1'b0;
    branch_offset_in = '0; exception_in = 1'b0; imem_ack_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nreq  = 0;
    seen  = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (imem_req_out) nreq++;
      if (fetch_fault_out) seen = 1'b1;
    end
    chk("fault_seen",   100, 32'(seen), 32'd1);
    chk("fault_cycle",  100, 32'(nreq), 32'(TO));
    chk("fault_pc_src", 100, 32'(pc_src_out), 32'd2);
    @(negedge clk);
    #1;
    chk("fault_pulse",  101, 32'(fetch_fault_out), 32'd0);
    chk("drain_req",    101, 32'(imem_req_out), 32'd1);
    chk("exc_pc",       101, pc, EXC_ADDR);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
